// File: rtl/arb_client_bank_if.sv
// Handshake bundle between an arbiter-side driver (master) and the client job bank (slave).
// Count width follows the bank's per-client job capacity.
interface arb_client_bank_if #(
    parameter int CLIENTS = 32,
    parameter int DEPTH   = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CLIENTS-1:0]    push;
    logic [CLIENTS-1:0]    grant;
    logic                  stall;
    logic                  clear;
    logic [CLIENTS-1:0]    request;
    logic [CLIENTS*CW-1:0] count;
    logic [CLIENTS-1:0]    starved;
    logic [CLIENTS-1:0]    overflow;
    logic                  protocol_err;

    modport master (
        output push, grant, stall, clear,
        input  request, count, starved, overflow, protocol_err
    );

    modport slave (
        input  push, grant, stall, clear,
        output request, count, starved, overflow, protocol_err
    );
endinterface

// File: rtl/arb_client_bank.sv
// Per-client job queues feeding a round-robin arbiter, with sticky monitors for
// starvation, dropped pushes and illegal grants.
module arb_client_bank #(
    parameter int CLIENTS  = 32,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 31
) (
    input  logic               clock,
    input  logic               reset,
    arb_client_bank_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(MAX_WAIT + 2);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT + 1);

    logic [CW-1:0]         r_count [CLIENTS];
    logic [WW-1:0]         r_wait  [CLIENTS];
    logic [CLIENTS-1:0]    r_starved;
    logic [CLIENTS-1:0]    r_overflow;
    logic                  r_protocolErr;

    logic [CLIENTS-1:0]    w_request;
    logic [CLIENTS-1:0]    w_acc;
    logic [CLIENTS-1:0]    w_full;
    logic [CLIENTS-1:0]    w_pushKept;
    logic [CLIENTS-1:0]    w_drop;
    logic [CLIENTS-1:0]    w_starveSet;
    logic [CW-1:0]         w_countNext [CLIENTS];
    logic [WW-1:0]         w_waitNext  [CLIENTS];
    logic [CLIENTS*CW-1:0] w_countPacked;
    logic                  w_multiGrant;
    logic                  w_orphanGrant;

    always_comb begin
        w_request     = '0;
        w_countPacked = '0;
        for (int i = 0; i < CLIENTS; i++) begin
            w_request[i]                = (r_count[i] != '0);
            w_countPacked[i*CW +: CW]   = r_count[i];
        end
    end

    // A push is kept when there is room, or when an accept frees a slot in the same cycle.
    always_comb begin
        w_acc         = '0;
        w_full        = '0;
        w_pushKept    = '0;
        w_drop        = '0;
        w_starveSet   = '0;
        w_countNext   = '{default: '0};
        w_waitNext    = '{default: '0};
        w_multiGrant  = 1'b0;
        w_orphanGrant = 1'b0;
        for (int i = 0; i < CLIENTS; i++) begin
            w_full[i]      = (r_count[i] == FULL_COUNT);
            w_acc[i]       = bus.grant[i] & w_request[i] & ~bus.stall;
            w_pushKept[i]  = bus.push[i] & (~w_full[i] | w_acc[i]);
            w_drop[i]      = bus.push[i] & w_full[i] & ~w_acc[i];
            w_countNext[i] = r_count[i] + CW'(w_pushKept[i]) - CW'(w_acc[i]);
            if (!w_request[i] || w_acc[i])
                w_waitNext[i] = '0;
            else if (bus.stall || r_wait[i] == WAIT_LIMIT)
                w_waitNext[i] = r_wait[i];
            else
                w_waitNext[i] = r_wait[i] + 1'b1;
            // Flag only on the transition into saturation so a clear stays effective.
            w_starveSet[i] = (w_waitNext[i] == WAIT_LIMIT) && (r_wait[i] != WAIT_LIMIT);
        end
        w_multiGrant  = (bus.grant & (bus.grant - CLIENTS'(1))) != '0;
        w_orphanGrant = |(bus.grant & ~w_request);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < CLIENTS; i++) begin
                r_count[i] <= '0;
                r_wait[i]  <= '0;
            end
            r_starved     <= '0;
            r_overflow    <= '0;
            r_protocolErr <= 1'b0;
        end else begin
            for (int i = 0; i < CLIENTS; i++) begin
                r_count[i] <= w_countNext[i];
                r_wait[i]  <= w_waitNext[i];
            end
            // Set conditions take priority over clear.
            r_starved     <= w_starveSet | (r_starved & ~{CLIENTS{bus.clear}});
            r_overflow    <= w_drop | (r_overflow & ~{CLIENTS{bus.clear}});
            r_protocolErr <= w_multiGrant | w_orphanGrant | (r_protocolErr & ~bus.clear);
        end
    end

    assign bus.request      = w_request;
    assign bus.count        = w_countPacked;
    assign bus.starved      = r_starved;
    assign bus.overflow     = r_overflow;
    assign bus.protocol_err = r_protocolErr;
endmodule

// File: tb/tb_arb_client_bank.sv
// Randomized and directed bench for arb_client_bank against a job-count model,
// including a closed loop with a behavioural round-robin arbiter.
module tb_arb_client_bank;
    localparam int CLIENTS  = 32;
    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 31;
    localparam int CW       = $clog2(DEPTH + 1);

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    arb_client_bank_if #(.CLIENTS(CLIENTS), .DEPTH(DEPTH)) bus();

    arb_client_bank #(.CLIENTS(CLIENTS), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int nCompared = 0;
    int nFailed   = 0;

    int               mJobs [CLIENTS];
    int               mWait [CLIENTS];
    logic [CLIENTS-1:0] mStarved = '0;
    logic [CLIENTS-1:0] mOverflow = '0;
    logic             mProto = 1'b0;
    int               keptPushes = 0;
    int               tbAccepts = 0;
    int               rrPtr = 0;

    // Model: jobs per client, consecutive unserved stall-free cycles, sticky flags.
    task automatic modelEdge();
        logic [CLIENTS-1:0] g, p, starveSet, ovfSet;
        logic st, cl, protoSet;
        g = bus.grant; p = bus.push; st = bus.stall; cl = bus.clear;
        if (!reset) begin
            for (int i = 0; i < CLIENTS; i++) begin mJobs[i] = 0; mWait[i] = 0; end
            mStarved = '0; mOverflow = '0; mProto = 1'b0;
            return;
        end
        starveSet = '0; ovfSet = '0;
        protoSet = ($countones(g) > 1);
        for (int i = 0; i < CLIENTS; i++) begin
            bit req, acc;
            req = (mJobs[i] > 0);
            acc = g[i] && req && !st;
            if (g[i] && !req) protoSet = 1'b1;
            if (p[i]) begin
                if (mJobs[i] < DEPTH || acc) begin mJobs[i]++; keptPushes++; end
                else ovfSet[i] = 1'b1;
            end
            if (acc) mJobs[i]--;
            if (!req || acc) mWait[i] = 0;
            else if (!st && mWait[i] <= MAX_WAIT) begin
                mWait[i]++;
                if (mWait[i] == MAX_WAIT + 1) starveSet[i] = 1'b1;
            end
        end
        mStarved  = starveSet | (cl ? '0 : mStarved);
        mOverflow = ovfSet | (cl ? '0 : mOverflow);
        mProto    = protoSet | (cl ? 1'b0 : mProto);
    endtask

    task automatic step();
        @(posedge clock);
        modelEdge();
        @(negedge clock);
    endtask

    function automatic logic [CLIENTS*CW-1:0] expCount();
        logic [CLIENTS*CW-1:0] v;
        v = '0;
        for (int i = 0; i < CLIENTS; i++) v[i*CW +: CW] = CW'(mJobs[i]);
        return v;
    endfunction

    function automatic logic [CLIENTS-1:0] expRequest();
        logic [CLIENTS-1:0] v;
        v = '0;
        for (int i = 0; i < CLIENTS; i++) v[i] = (mJobs[i] > 0);
        return v;
    endfunction

    task automatic applyReset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b0;
        bus.push = '1;
        step();
        step();
        nCompared++;
        if (bus.request !== '0) begin nFailed++; $display("[TB] FAIL reset_request: got %h expected 0", bus.request); end
        nCompared++;
        if (bus.count !== '0) begin nFailed++; $display("[TB] FAIL reset_count: got %h expected 0", bus.count); end
        nCompared++;
        if ({bus.starved, bus.overflow, bus.protocol_err} !== '0) begin
            nFailed++; $display("[TB] FAIL reset_flags: got %h/%h/%b expected all 0", bus.starved, bus.overflow, bus.protocol_err);
        end
        reset = 1'b1;
        bus.push = 32'h0000_0010;
        step();
        bus.push = '0;
        nCompared++;
        if (bus.request !== 32'h0000_0010) begin nFailed++; $display("[TB] FAIL reset_first_push: got %h expected 00000010", bus.request); end
    endtask

    task automatic test_fill_drain();
        bus.push = 32'h0000_0010;
        repeat (3) step();
        nCompared++;
        if (bus.count[4*CW +: CW] !== 3'd4) begin nFailed++; $display("[TB] FAIL fill_count4: got %0d expected 4", bus.count[4*CW +: CW]); end
        step();
        bus.push = '0;
        nCompared++;
        if (bus.overflow[4] !== 1'b1 || bus.count[4*CW +: CW] !== 3'd4) begin
            nFailed++; $display("[TB] FAIL fill_overflow: got ovf=%b cnt=%0d expected ovf=1 cnt=4", bus.overflow[4], bus.count[4*CW +: CW]);
        end
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        nCompared++;
        if (bus.overflow !== '0) begin nFailed++; $display("[TB] FAIL fill_clear: got %h expected 0", bus.overflow); end
        for (int k = 0; k < 4; k++) begin
            bus.grant = 32'h0000_0010;
            step();
            nCompared++;
            if (bus.request[4] !== (k < 3)) begin nFailed++; $display("[TB] FAIL drain_req4_%0d: got %b expected %b", k, bus.request[4], k < 3); end
        end
        bus.grant = '0;
        nCompared++;
        if (bus.count !== expCount()) begin nFailed++; $display("[TB] FAIL drain_count: got %h expected %h", bus.count, expCount()); end
    endtask

    task automatic test_push_accept_full();
        bus.push = 32'h0000_0010;
        repeat (4) step();
        bus.grant = 32'h0000_0010;
        step();
        bus.push = '0;
        nCompared++;
        if (bus.count[4*CW +: CW] !== 3'd4 || bus.overflow[4] !== 1'b0) begin
            nFailed++; $display("[TB] FAIL full_push_accept: got cnt=%0d ovf=%b expected cnt=4 ovf=0", bus.count[4*CW +: CW], bus.overflow[4]);
        end
        repeat (4) step();
        bus.grant = '0;
        nCompared++;
        if (bus.request !== '0) begin nFailed++; $display("[TB] FAIL full_drain: got %h expected 0", bus.request); end
    endtask

    task automatic test_starvation();
        bus.push = 32'h0000_0080;
        step();
        bus.push = '0;
        for (int c = 1; c <= 32; c++) begin
            step();
            if (c >= 31) begin
                nCompared++;
                if (bus.starved[7] !== (c == 32)) begin nFailed++; $display("[TB] FAIL starve_nostall_%0d: got %b expected %b", c, bus.starved[7], c == 32); end
            end
        end
        bus.grant = 32'h0000_0080;
        bus.clear = 1'b1;
        step();
        bus.grant = '0;
        bus.clear = 1'b0;
        nCompared++;
        if (bus.starved !== '0 || bus.request[7] !== 1'b0) begin
            nFailed++; $display("[TB] FAIL starve_clear1: got st=%h req7=%b expected 0/0", bus.starved, bus.request[7]);
        end
        bus.push = 32'h0000_0080;
        step();
        bus.push = '0;
        for (int c = 1; c <= 42; c++) begin
            bus.stall = (c >= 5 && c < 15);
            step();
            if (c >= 41) begin
                nCompared++;
                if (bus.starved[7] !== (c == 42)) begin nFailed++; $display("[TB] FAIL starve_stall_%0d: got %b expected %b", c, bus.starved[7], c == 42); end
            end
        end
        bus.stall = 1'b0;
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        step();
        nCompared++;
        if (bus.starved[7] !== 1'b0 || bus.starved !== mStarved) begin nFailed++; $display("[TB] FAIL starve_clear2: got %h expected 0", bus.starved); end
        bus.grant = 32'h0000_0080;
        step();
        bus.grant = '0;
    endtask

    task automatic test_protocol();
        bus.grant = 32'h0000_0003;
        step();
        bus.grant = '0;
        nCompared++;
        if (bus.protocol_err !== 1'b1) begin nFailed++; $display("[TB] FAIL proto_multi: got %b expected 1", bus.protocol_err); end
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        nCompared++;
        if (bus.protocol_err !== 1'b0) begin nFailed++; $display("[TB] FAIL proto_clear: got %b expected 0", bus.protocol_err); end
        bus.grant = 32'h0000_0200;
        step();
        bus.grant = '0;
        nCompared++;
        if (bus.protocol_err !== 1'b1) begin nFailed++; $display("[TB] FAIL proto_orphan: got %b expected 1", bus.protocol_err); end
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    // Random push/grant/stall/clear on a few clients, with occasional illegal grants.
    task automatic test_back_to_back();
        applyReset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [CLIENTS-1:0] g;
            int start, pick;
            g = '0;
            pick = -1;
            start = $urandom_range(0, 3);
            for (int k = 0; k < 4; k++) if (pick < 0 && mJobs[(start + k) % 4] > 0) pick = (start + k) % 4;
            if (pick >= 0 && $urandom_range(0, 3) != 0) g[pick] = 1'b1;
            if ($urandom_range(0, 49) == 0) g[$urandom_range(0, 7)] = 1'b1;
            bus.grant = g;
            bus.push  = CLIENTS'($urandom_range(0, 15) & $urandom_range(0, 15));
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.clear = ($urandom_range(0, 15) == 0);
            step();
            nCompared++;
            if (bus.count !== expCount()) begin nFailed++; $display("[TB] FAIL b2b_count@%0d: got %h expected %h", cyc, bus.count, expCount()); end
            nCompared++;
            if (bus.request !== expRequest()) begin nFailed++; $display("[TB] FAIL b2b_request@%0d: got %h expected %h", cyc, bus.request, expRequest()); end
            nCompared++;
            if (bus.starved !== mStarved) begin nFailed++; $display("[TB] FAIL b2b_starved@%0d: got %h expected %h", cyc, bus.starved, mStarved); end
            nCompared++;
            if (bus.overflow !== mOverflow) begin nFailed++; $display("[TB] FAIL b2b_overflow@%0d: got %h expected %h", cyc, bus.overflow, mOverflow); end
            nCompared++;
            if (bus.protocol_err !== mProto) begin nFailed++; $display("[TB] FAIL b2b_proto@%0d: got %b expected %b", cyc, bus.protocol_err, mProto); end
        end
        bus.grant = '0; bus.stall = 1'b0; bus.clear = 1'b0;
        bus.push  = '1;
        applyReset();
        bus.push  = '0;
        nCompared++;
        if (bus.request !== '0 || bus.count !== '0) begin nFailed++; $display("[TB] FAIL b2b_midreset: got req=%h cnt=%h expected 0", bus.request, bus.count); end
    endtask

    task automatic test_closed_loop();
        int sumCounts;
        keptPushes = 0;
        tbAccepts  = 0;
        rrPtr      = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [CLIENTS-1:0] p, g;
            int pick;
            p = '0; g = '0; pick = -1;
            for (int i = 0; i < CLIENTS; i++) p[i] = ($urandom_range(0, 47) == 0);
            for (int k = 0; k < CLIENTS; k++) if (pick < 0 && mJobs[(rrPtr + k) % CLIENTS] > 0) pick = (rrPtr + k) % CLIENTS;
            if (pick >= 0) begin g[pick] = 1'b1; rrPtr = (pick + 1) % CLIENTS; end
            bus.push  = p;
            bus.grant = g;
            tbAccepts += $countones(g & bus.request);
            step();
            nCompared++;
            if (bus.count !== expCount()) begin nFailed++; $display("[TB] FAIL loop_count@%0d: got %h expected %h", cyc, bus.count, expCount()); end
            nCompared++;
            if (bus.starved !== '0 || bus.protocol_err !== 1'b0) begin
                nFailed++; $display("[TB] FAIL loop_flags@%0d: got st=%h perr=%b expected 0/0", cyc, bus.starved, bus.protocol_err);
            end
        end
        bus.push  = '0;
        bus.grant = '0;
        sumCounts = 0;
        for (int i = 0; i < CLIENTS; i++) sumCounts += int'(bus.count[i*CW +: CW]);
        nCompared++;
        if (tbAccepts !== keptPushes - sumCounts) begin
            nFailed++; $display("[TB] FAIL loop_conservation: got accepts=%0d expected %0d", tbAccepts, keptPushes - sumCounts);
        end
    endtask

    initial begin
        bus.push  = '0;
        bus.grant = '0;
        bus.stall = 1'b0;
        bus.clear = 1'b0;
        for (int i = 0; i < CLIENTS; i++) begin mJobs[i] = 0; mWait[i] = 0; end
        test_reset();
        test_fill_drain();
        test_push_accept_full();
        test_starvation();
        test_protocol();
        test_back_to_back();
        test_closed_loop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end
endmodule

// File: doc/arb_client_bank.md
# arb_client_bank

Request-side counterpart of `rr_arbiter`. It queues work for `CLIENTS` independent clients and drives the `request` vector into the arbiter. Each request is held high until the matching `grant` is accepted, and the block consumes one job per accepted grant. It also monitors the arbiter side of the handshake and raises sticky flags for:
- starvation (no grant within a bounded wait),
- job overflow,
- protocol violations on `grant`.

## Interface
Parameters:
- `CLIENTS`, 32, number of clients; width of `push`, `request` and `grant`.
- `DEPTH`, 4, maximum outstanding jobs per client (≥1).
- `MAX_WAIT`, 31, maximum number of stall-free cycles a request may wait before it is flagged as starved.
- `CW`, `$clog2(DEPTH+1)`, width of a per-client job count; derived, not overridable.

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `push` in `CLIENTS`: `push[i]` high adds one job to client i in that cycle.
- `grant` in `CLIENTS`: one-hot grant from the arbiter.
- `stall` in 1: arbiter stall; while high, no grant is accepted.
- `clear` in 1: clears all sticky flags.
- `request` out `CLIENTS`: `request[i] = (count[i] != 0)`, decoded directly from registers.
- `count` out `CLIENTS*CW`: packed per-client job counts; client i occupies bits `[i*CW +: CW]`.
- `starved` out `CLIENTS`: sticky; per-client starvation flag.
- `overflow` out `CLIENTS`: sticky; a push to client i was dropped because its queue was full.
- `protocol_err` out 1: sticky; an illegal grant was seen.

## Operation
- Accept rule: `acc[i] = grant[i] & request[i] & !stall`.
- Count update per client each cycle: `count[i] <= count[i] + (push[i] & ~full[i] | push[i] & acc[i]) - acc[i]`.
  - `full[i]` is `count[i] == DEPTH`.
- Push and accept in the same cycle: the count is unchanged. This holds even when the queue is full; the push is not dropped.
- Push while full without an accept: the push is dropped, the count stays at `DEPTH`, and `overflow[i]` is set in the next cycle.
- Accept when `count[i] == 1` with no push: `request[i]` falls in the next cycle.
- The count never underflows, because an accept requires `request[i]`, which requires `count[i] ≥ 1`.
- Per-client wait counter `wait[i]`, width `$clog2(MAX_WAIT+2)`:
  - cleared to 0 when `request[i]` is low or `acc[i]` is high;
  - held while `stall` is high;
  - otherwise incremented, saturating at `MAX_WAIT+1`.
- `starved[i]` is set on the cycle `wait[i]` reaches `MAX_WAIT+1`. The flag becomes visible in the cycle after `MAX_WAIT+1` consecutive stall-free cycles of unaccepted request.
- `protocol_err` is set in the cycle after either condition, regardless of `stall`:
  - `grant` has more than one bit high;
  - `grant[i]` is high while `request[i]` is low.
- `clear` zeroes `starved`, `overflow` and `protocol_err` in the next cycle. It has no effect on counts or wait counters. If `clear` and a set condition occur in the same cycle, set wins.
- Every client is independent; there is no cross-client priority inside this block.

## Timing
- Reset (`reset` low at an edge) forces: all counts 0, all wait counters 0, `request` 0, `starved` 0, `overflow` 0, `protocol_err` 0. During reset, inputs are ignored.
- Reset asserted mid-operation discards all queued jobs. `request` is 0 in the first cycle after the reset edge.
- Push to request latency is 1 cycle: `push[i]` at cycle n on an empty client gives `request[i]` high at n+1.
- A grant is consumed in the same cycle it is accepted; the count and `request` reflect it at the next edge.
- `request[i]` never drops while `count[i] > 0`. This satisfies the arbiter's requirement that a request is held stable until granted.
- All outputs are registered or decoded only from registers; there is no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with `push` all ones → `request`=0, all counts 0, all flags 0. After release, a push to client 4 → `request[4]`=1 one cycle later.
- **Fill and drain, client 4:**
  - 4 pushes → `count[4]`=4.
  - 5th push with no grant → `overflow[4]`=1 and the count stays 4.
  - 4 accepted grants → `request[4]` falls after the 4th accept.
- **Simultaneous push and accept at full:** `count[4]`=4, push and grant in the same cycle → count stays 4 and `overflow[4]` stays 0.
- **Starvation:** `request[7]` held with no grant for 32 stall-free cycles → `starved[7]`=1 on the next cycle. Repeat with `stall` high for 10 of those cycles → flag delayed by exactly 10 cycles. Pulse `clear` → flag returns to 0.
- **Protocol errors:**
  - `grant`=`32'h0000_0003` → `protocol_err`=1 next cycle.
  - After `clear`, `grant[9]`=1 with `request[9]`=0 → `protocol_err`=1 again.
- **Closed loop with `rr_arbiter` (32 clients, `stall`=0), random pushes:** `starved` stays 0, `protocol_err` stays 0, and total accepts equal total non-dropped pushes minus the final sum of counts.
